// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and 16-bit key-map helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_REL = 2'd2
  } kp_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [3:0] onehot_index16(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all ones (idle pulled-up rows).
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronised row sampling,
// whole-map debounce and a single-key press/release tracker.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int unsigned DIV_BITS       = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_down
);

  localparam int unsigned CntW = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS - 1);

  logic [DIV_BITS+1:0]  cnt_q, cnt_d;
  logic [1:0]           col, col_next;
  logic                 sample;
  logic [NUM_ROWS-1:0]  rows_sync;
  logic [NUM_COLS-1:0]  col_n_q, col_n_d;

  logic [NUM_KEYS-1:0]  scan_q, scan_d, scan_full;
  logic [NUM_KEYS-1:0]  prev_q, prev_d;
  logic [NUM_KEYS-1:0]  deb_q, deb_d;
  logic [CntW-1:0]      stable_q, stable_d;
  logic                 deb_stb_q, deb_stb_d;
  logic [3:0]           bit_idx;

  kp_state_t            state_q, state_d;
  logic [KEY_W-1:0]     key_code_q, key_code_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_down_q, key_down_d;

  sync2 #(
    .WIDTH(NUM_ROWS)
  ) u_rows_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (rows_n),
    .q_o  (rows_sync)
  );

  // Divider and column drive; col_n follows the column of the next count so it
  // lines up with the count during each dwell.
  assign col      = cnt_q[DIV_BITS+1:DIV_BITS];
  assign cnt_d    = cnt_q + 1'b1;
  assign col_next = cnt_d[DIV_BITS+1:DIV_BITS];
  assign col_n_d  = ~(4'b0001 << col_next);
  assign sample   = &cnt_q[DIV_BITS-1:0];

  always_comb begin
    scan_full = scan_q;
    scan_d    = scan_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    deb_d     = deb_q;
    deb_stb_d = 1'b0;
    bit_idx   = '0;
    if (sample) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        bit_idx            = {2'(r), col};
        scan_full[bit_idx] = ~rows_sync[2'(r)];
      end
      scan_d = scan_full;
      if (col == 2'd3) begin
        prev_d = scan_full;
        if (scan_full == prev_q) begin
          stable_d = (stable_q == CntMax) ? CntMax : stable_q + 1'b1;
        end else begin
          stable_d = '0;
        end
        // Re-commits on every stable scan once saturated; the FSM tolerates repeats.
        if (stable_d == CntMax) begin
          deb_d     = scan_full;
          deb_stb_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (deb_stb_q) begin
      case (state_q)
        IDLE: begin
          if (popcount16(deb_q) == 5'd1) begin
            key_code_d  = onehot_index16(deb_q);
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = HELD;
          end else if (deb_q != '0) begin
            state_d = WAIT_REL;
          end
        end
        HELD: begin
          if (deb_q == '0) begin
            key_down_d = 1'b0;
            state_d    = IDLE;
          end
        end
        WAIT_REL: begin
          if (deb_q == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      col_n_q     <= 4'b1110;
      scan_q      <= '0;
      prev_q      <= '0;
      deb_q       <= '0;
      stable_q    <= '0;
      deb_stb_q   <= 1'b0;
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      col_n_q     <= col_n_d;
      scan_q      <= scan_d;
      prev_q      <= prev_d;
      deb_q       <= deb_d;
      stable_q    <= stable_d;
      deb_stb_q   <= deb_stb_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
